// File: rtl/fml_rr_arb.sv
// -----------------------------------------------------------------------------
// fml_rr_arb
//   Round-robin arbiter that lets up to four FML requesters share one FML
//   (SDRAM) port. A requester is picked in IDLE, its strobe is forwarded in
//   REQ until the memory acknowledges, and the remaining beats of the burst
//   are counted in BURST before the next arbitration. The round-robin pointer
//   only advances after a completed transfer, so an aborted request does not
//   cost the aborting requester its turn.
//
// Handshake: a requester holds m_stb_i together with its address, write enable,
//   byte selects and write data until it sees its m_ack_o bit. That ack cycle
//   carries the first beat; burst_len-1 further beats follow on consecutive
//   cycles with no extra handshake. A requester may drop its strobe before the
//   ack to abort.
//
// Ports
//   clk_sys_i, rst_n_i      system clock, asynchronous active-low reset
//   m_adr_i/stb/we/sel/do   requester side, requester k in slice k
//   m_ack_o                 per-requester ack (only the granted one can be 1)
//   m_di_o                  read data broadcast to every requester
//   fml_adr/stb/we/sel/do   shared FML master port
//   fml_ack, fml_di         FML acknowledge and read data
//   grant_o                 index of the current or last granted requester
//   dbg_state_o             FSM state (0 IDLE, 1 REQ, 2 BURST)
// -----------------------------------------------------------------------------
module fml_rr_arb #(
    parameter int sdram_depth = 26,
    parameter int n_masters   = 2,
    parameter int burst_len   = 4
) (
    input  logic                           clk_sys_i,
    input  logic                           rst_n_i,
    input  logic [n_masters*sdram_depth-1:0] m_adr_i,
    input  logic [n_masters-1:0]           m_stb_i,
    input  logic [n_masters-1:0]           m_we_i,
    input  logic [n_masters*4-1:0]         m_sel_i,
    input  logic [n_masters*32-1:0]        m_do_i,
    output logic [n_masters-1:0]           m_ack_o,
    output logic [31:0]                    m_di_o,
    output logic [sdram_depth-1:0]         fml_adr,
    output logic                           fml_stb,
    output logic                           fml_we,
    output logic [3:0]                     fml_sel,
    output logic [31:0]                    fml_do,
    input  logic                           fml_ack,
    input  logic [31:0]                    fml_di,
    output logic [1:0]                     grant_o,
    output logic [1:0]                     dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BURST = 2'd2
    } state_t;

    localparam logic [2:0] LAST_BEAT = 3'(burst_len - 1);

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [2:0] cnt_q,   cnt_d;

    logic       gnt_stb;
    logic       found;
    logic [1:0] pick_idx;
    logic [1:0] ptr_next;

    // Round-robin pick: first the requesters at or above ptr, then wrap to
    // the ones below it. ptr is always < n_masters, so only legal indices
    // can be picked.
    always_comb begin
        found    = 1'b0;
        pick_idx = ptr_q;
        for (int k = 0; k < n_masters; k++) begin
            if (!found && m_stb_i[k] && (2'(k) >= ptr_q)) begin
                found    = 1'b1;
                pick_idx = 2'(k);
            end
        end
        for (int k = 0; k < n_masters; k++) begin
            if (!found && m_stb_i[k]) begin
                found    = 1'b1;
                pick_idx = 2'(k);
            end
        end
    end

    assign ptr_next = (grant_q == 2'(n_masters - 1)) ? 2'd0 : grant_q + 2'd1;

    // Shared-port mux follows the grant register in every state; requester 0
    // is the fallback so the port mirrors it while in reset.
    always_comb begin
        fml_adr = m_adr_i[0 +: sdram_depth];
        fml_we  = m_we_i[0];
        fml_sel = m_sel_i[0 +: 4];
        fml_do  = m_do_i[0 +: 32];
        gnt_stb = m_stb_i[0];
        for (int k = 1; k < n_masters; k++) begin
            if (grant_q == 2'(k)) begin
                fml_adr = m_adr_i[k*sdram_depth +: sdram_depth];
                fml_we  = m_we_i[k];
                fml_sel = m_sel_i[k*4 +: 4];
                fml_do  = m_do_i[k*32 +: 32];
                gnt_stb = m_stb_i[k];
            end
        end
    end

    // Outputs decode from registered state only, so an asynchronous reset
    // clears fml_stb and m_ack_o immediately.
    always_comb begin
        fml_stb = (state_q == REQ) && gnt_stb;
        m_ack_o = '0;
        for (int k = 0; k < n_masters; k++) begin
            m_ack_o[k] = (state_q != IDLE) && fml_ack && (grant_q == 2'(k));
        end
    end

    assign m_di_o      = fml_di;
    assign grant_o     = grant_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|m_stb_i) begin
                    grant_d = pick_idx;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (fml_ack) begin
                    if (burst_len == 1) begin
                        state_d = IDLE;
                        ptr_d   = ptr_next;
                    end else begin
                        state_d = BURST;
                        cnt_d   = 3'd1;
                    end
                end else if (!gnt_stb) begin
                    // Abort: the requester keeps its round-robin position.
                    state_d = IDLE;
                end
            end
            BURST: begin
                if (cnt_q == LAST_BEAT) begin
                    state_d = IDLE;
                    ptr_d   = ptr_next;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            grant_q <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fml_rr_arb.sv
// -----------------------------------------------------------------------------
// tb_fml_rr_arb
//   Two arbiter instances: u_dut2 (two requesters) carries the directed
//   scenarios, u_dut3 (three requesters) the three-way rotation. Driver tasks
//   present requests and play the FML slave; expected transactions and acks
//   are queued when the stimulus is issued, and a negedge monitor pops and
//   compares whenever the arbiter raises fml_stb or an m_ack_o bit.
// -----------------------------------------------------------------------------
module tb_fml_rr_arb;

    localparam int AW = 26;
    localparam int BL = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- two-requester instance ----------------
    logic [2*AW-1:0] m_adr;
    logic [1:0]      m_stb, m_we, m_ack;
    logic [7:0]      m_sel;
    logic [63:0]     m_do;
    logic [31:0]     m_di;
    logic [AW-1:0]   fml_adr;
    logic            fml_stb, fml_we, fml_ack;
    logic [3:0]      fml_sel;
    logic [31:0]     fml_do, fml_di;
    logic [1:0]      grant, dbg_state;

    fml_rr_arb #(.sdram_depth(AW), .n_masters(2), .burst_len(BL)) u_dut2 (
        .clk_sys_i(clk), .rst_n_i(rst_n),
        .m_adr_i(m_adr), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
        .m_do_i(m_do), .m_ack_o(m_ack), .m_di_o(m_di),
        .fml_adr(fml_adr), .fml_stb(fml_stb), .fml_we(fml_we),
        .fml_sel(fml_sel), .fml_do(fml_do), .fml_ack(fml_ack), .fml_di(fml_di),
        .grant_o(grant), .dbg_state_o(dbg_state)
    );

    // ---------------- three-requester instance ----------------
    logic [3*AW-1:0] m3_adr;
    logic [2:0]      m3_stb, m3_we, m3_ack;
    logic [11:0]     m3_sel;
    logic [95:0]     m3_do;
    logic [31:0]     m3_di;
    logic [AW-1:0]   f3_adr;
    logic            f3_stb, f3_we, f3_ack;
    logic [3:0]      f3_sel;
    logic [31:0]     f3_do, f3_di;
    logic [1:0]      grant3, dbg_state3;

    fml_rr_arb #(.sdram_depth(AW), .n_masters(3), .burst_len(BL)) u_dut3 (
        .clk_sys_i(clk), .rst_n_i(rst_n),
        .m_adr_i(m3_adr), .m_stb_i(m3_stb), .m_we_i(m3_we), .m_sel_i(m3_sel),
        .m_do_i(m3_do), .m_ack_o(m3_ack), .m_di_o(m3_di),
        .fml_adr(f3_adr), .fml_stb(f3_stb), .fml_we(f3_we),
        .fml_sel(f3_sel), .fml_do(f3_do), .fml_ack(f3_ack), .fml_di(f3_di),
        .grant_o(grant3), .dbg_state_o(dbg_state3)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [64:0] exp_q[$];   // {grant, adr, we, sel, do}
    logic [1:0]  ack_q[$];   // expected m_ack_o pattern
    logic [1:0]  g3_q[$];    // expected grant order on u_dut3

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic flag(input string nm);
        total++;
        bad++;
        $display("FAIL %s: event missing or unexpected (t=%0t)", nm, $time);
    endtask

    function automatic logic [64:0] txn(input logic [1:0] g, input logic [AW-1:0] a,
                                        input logic we, input logic [3:0] sel,
                                        input logic [31:0] d);
        return {g, a, we, sel, d};
    endfunction

    // ---------------- monitor ----------------
    logic stb_prev  = 1'b0;
    logic stb3_prev = 1'b0;
    always @(negedge clk) begin
        if (fml_stb && !stb_prev) begin
            if (exp_q.size() == 0) flag("unexpected_stb");
            else chk("txn", {grant, fml_adr, fml_we, fml_sel, fml_do}, exp_q.pop_front());
        end
        stb_prev = fml_stb;
        if (m_ack != 2'b00) begin
            if (ack_q.size() == 0) flag("unexpected_ack");
            else chk("ack", 65'(m_ack), 65'(ack_q.pop_front()));
        end
        if (f3_stb && !stb3_prev) begin
            if (g3_q.size() == 0) flag("unexpected_stb3");
            else chk("grant3", 65'(grant3), 65'(g3_q.pop_front()));
        end
        stb3_prev = f3_stb;
    end

    // ---------------- driver tasks ----------------
    task automatic req(input int k, input logic [AW-1:0] a, input logic we,
                       input logic [3:0] sel, input logic [31:0] d);
        m_adr[k*AW +: AW] = a;
        m_we[k]           = we;
        m_sel[k*4 +: 4]   = sel;
        m_do[k*32 +: 32]  = d;
        m_stb[k]          = 1'b1;
    endtask

    task automatic wait_stb(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (fml_stb) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) flag("stb_timeout");
    endtask

    // FML slave: ack `delay` cycles (>=1) after the strobe is seen, then
    // follow the burst and check the FSM is in BURST on the last beat and
    // back in IDLE the cycle after.
    task automatic serve(input int k, input int delay, input bit drop);
        bit ok;
        wait_stb(ok);
        if (!ok) return;
        repeat (delay) @(posedge clk);
        #1;
        fml_ack = 1'b1;
        fml_di  = $urandom;
        ack_q.push_back(2'(1 << k));
        #1 chk("di_bcast", 65'(m_di), 65'(fml_di));
        @(posedge clk);
        #1;
        fml_ack = 1'b0;
        if (drop) m_stb[k] = 1'b0;
        repeat (BL - 2) @(posedge clk);
        @(negedge clk);
        chk("burst_last_beat", 65'(dbg_state), 65'(2));
        @(posedge clk);
        @(negedge clk);
        chk("idle_after_burst", 65'(dbg_state), 65'(0));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        int n;
        rst_n   = 1'b0;
        m_adr   = '0; m_stb = '0; m_we = '0; m_sel = '0; m_do = '0;
        fml_ack = 1'b0; fml_di = '0;
        m3_adr  = '0; m3_stb = '0; m3_we = '0; m3_sel = '0; m3_do = '0;
        f3_ack  = 1'b0; f3_di = '0;

        // Reset state with both requesters already strobing.
        req(0, 26'h200, 1'b0, 4'hF, 32'h1111_0000);
        req(1, 26'h300, 1'b1, 4'hC, 32'h2222_0000);
        #12;
        chk("rst_fml_stb", 65'(fml_stb), 65'(0));
        chk("rst_ack",     65'(m_ack),   65'(0));
        chk("rst_grant",   65'(grant),   65'(0));
        chk("rst_state",   65'(dbg_state), 65'(0));
        chk("rst_mux", {fml_adr, fml_we, fml_sel, fml_do},
            {26'h200, 1'b0, 4'hF, 32'h1111_0000});

        // Contention right after reset: m0, m1, then m0 again.
        exp_q.push_back(txn(2'd0, 26'h200, 1'b0, 4'hF, 32'h1111_0000));
        exp_q.push_back(txn(2'd1, 26'h300, 1'b1, 4'hC, 32'h2222_0000));
        @(posedge clk); #1 rst_n = 1'b1;
        serve(0, 1, 1'b0);
        req(0, 26'h204, 1'b0, 4'hF, 32'h1111_0004);
        exp_q.push_back(txn(2'd0, 26'h204, 1'b0, 4'hF, 32'h1111_0004));
        serve(1, 2, 1'b1);
        serve(0, 1, 1'b1);

        // Write through requester 1.
        @(posedge clk); #1;
        req(1, 26'h0AB, 1'b1, 4'h3, 32'hDEAD_BEEF);
        exp_q.push_back(txn(2'd1, 26'h0AB, 1'b1, 4'h3, 32'hDEAD_BEEF));
        serve(1, 2, 1'b1);

        // Single read from requester 0, ack 3 cycles after the strobe.
        @(posedge clk); #1;
        req(0, 26'h100, 1'b0, 4'hF, 32'h0);
        exp_q.push_back(txn(2'd0, 26'h100, 1'b0, 4'hF, 32'h0));
        serve(0, 3, 1'b1);

        // Abort by requester 1: pointer must stay at 1.
        @(posedge clk); #1;
        req(1, 26'h1F0, 1'b0, 4'hF, 32'h0);
        exp_q.push_back(txn(2'd1, 26'h1F0, 1'b0, 4'hF, 32'h0));
        wait_stb(ok);
        #1 m_stb[1] = 1'b0;
        #1;
        chk("abort_stb_falls", 65'(fml_stb), 65'(0));
        chk("abort_still_req", 65'(dbg_state), 65'(1));
        @(posedge clk); @(negedge clk);
        chk("abort_idle", 65'(dbg_state), 65'(0));
        req(0, 26'h010, 1'b0, 4'hF, 32'h0);
        req(1, 26'h020, 1'b0, 4'hF, 32'h0);
        exp_q.push_back(txn(2'd1, 26'h020, 1'b0, 4'hF, 32'h0));
        exp_q.push_back(txn(2'd0, 26'h010, 1'b0, 4'hF, 32'h0));
        serve(1, 1, 1'b1);
        serve(0, 1, 1'b1);

        // Reset in the middle of a burst (cnt==2), with fml_ack high.
        @(posedge clk); #1;
        req(0, 26'h3C0, 1'b0, 4'hF, 32'h0);
        exp_q.push_back(txn(2'd0, 26'h3C0, 1'b0, 4'hF, 32'h0));
        wait_stb(ok);
        @(posedge clk); #1;
        fml_ack = 1'b1;
        ack_q.push_back(2'b01);
        @(posedge clk); #1;
        fml_ack  = 1'b0;
        m_stb[0] = 1'b0;
        @(posedge clk); #2;
        fml_ack = 1'b1;
        rst_n   = 1'b0;
        #1;
        chk("midrst_fml_stb", 65'(fml_stb),   65'(0));
        chk("midrst_ack",     65'(m_ack),     65'(0));
        chk("midrst_state",   65'(dbg_state), 65'(0));
        @(posedge clk); #1 fml_ack = 1'b0;
        req(0, 26'h050, 1'b0, 4'hF, 32'h0);
        req(1, 26'h060, 1'b0, 4'hF, 32'h0);
        exp_q.push_back(txn(2'd0, 26'h050, 1'b0, 4'hF, 32'h0));
        exp_q.push_back(txn(2'd1, 26'h060, 1'b0, 4'hF, 32'h0));
        @(posedge clk); #1 rst_n = 1'b1;
        serve(0, 1, 1'b1);
        serve(1, 1, 1'b1);

        // Three requesters strobing continuously: grants 0,1,2,0 and
        // burst_len stb-low cycles between consecutive transfers.
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) m3_adr[k*AW +: AW] = AW'(26'h40 * (k + 1));
        m3_stb = 3'b111;
        g3_q.push_back(2'd0); g3_q.push_back(2'd1);
        g3_q.push_back(2'd2); g3_q.push_back(2'd0);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            ok = f3_stb;
        end
        if (!ok) flag("stb3_timeout");
        for (int t = 0; t < 4 && ok; t++) begin
            @(posedge clk); #1 f3_ack = 1'b1;
            @(posedge clk); #1 f3_ack = 1'b0;
            if (t == 3) begin
                m3_stb = 3'b000;
            end else begin
                n  = 0;
                ok = 1'b0;
                for (int i = 0; i < 20 && !ok; i++) begin
                    @(negedge clk);
                    if (f3_stb) ok = 1'b1;
                    else n++;
                end
                if (!ok) flag("stb3_gap_timeout");
                else chk("gap3", 65'(n), 65'(BL));
            end
        end

        repeat (8) @(posedge clk);
        chk("exp_q_drained", 65'(exp_q.size()), 65'(0));
        chk("ack_q_drained", 65'(ack_q.size()), 65'(0));
        chk("g3_q_drained",  65'(g3_q.size()),  65'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fml_rr_arb.md
FML_RR_ARB -- requirements
Module: fml_rr_arb

Interface
REQ-001 Parameter sdram_depth, default 26: FML address width.
REQ-002 Parameter n_masters, default 2, legal 2..4: number of FML requesters.
REQ-003 Parameter burst_len, default 4: data beats per FML transfer, counting the ack beat.
REQ-004 clk_sys_i  in  1  single system clock; all state changes on rising edge.
REQ-005 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-006 m_adr_i  in  n_masters*sdram_depth  requester addresses; requester k occupies slice k.
REQ-007 m_stb_i  in  n_masters  requester strobes.
REQ-008 m_we_i  in  n_masters  requester write enables.
REQ-009 m_sel_i  in  n_masters*4  requester byte selects.
REQ-010 m_do_i  in  n_masters*32  requester write data.
REQ-011 m_ack_o  out  n_masters  per-requester ack.
REQ-012 m_di_o  out  32  read data, broadcast to all requesters.
REQ-013 fml_adr  out  sdram_depth  shared FML address.
REQ-014 fml_stb  out  1  shared FML strobe.
REQ-015 fml_we  out  1  shared FML write enable.
REQ-016 fml_sel  out  4  shared FML byte select.
REQ-017 fml_do  out  32  shared FML write data.
REQ-018 fml_ack  in  1  FML acknowledge.
REQ-019 fml_di  in  32  FML read data.
REQ-020 grant_o  out  2  index of the current or last granted requester.

Function
REQ-021 The block SHALL use states IDLE, REQ and BURST, plus these registers:
- grant (2 bits)
- rr pointer ptr (2 bits)
- beat counter cnt (3 bits)
REQ-022 In IDLE with any m_stb_i bit set, the block SHALL pick the first set index searching ptr, ptr+1, ... mod n_masters, then:
- latch it into grant
- enter REQ on the next edge.
REQ-023 In IDLE with no strobe, the block SHALL stay in IDLE and leave grant unchanged.
REQ-024 fml_adr, fml_we, fml_sel and fml_do SHALL be combinational muxes of the granted requester's slices in every state.
REQ-025 fml_stb SHALL equal m_stb_i[grant] in REQ and SHALL be 0 in IDLE and BURST.
REQ-026 m_ack_o[grant] SHALL equal fml_ack in REQ and BURST; all other m_ack_o bits SHALL be 0.
REQ-027 m_di_o SHALL equal fml_di combinationally in all states.
REQ-028 Timing: a strobe sampled in IDLE at cycle t SHALL give fml_stb=1 at cycle t+1; arbitration latency is 1 cycle.
REQ-029 In REQ with fml_ack=1, the block SHALL enter BURST with cnt=1.
REQ-030 In BURST, cnt SHALL increment each cycle.
REQ-031 When cnt==burst_len-1, the block SHALL:
- return to IDLE
- set ptr=(grant+1) mod n_masters.
REQ-032 For burst_len=1, REQ with fml_ack SHALL go directly to IDLE and update ptr.
REQ-033 In REQ with m_stb_i[grant]=0 and fml_ack=0 (requester abort), the block SHALL return to IDLE with ptr unchanged.
REQ-034 Other requesters' strobes SHALL have no effect outside IDLE; they remain pending.
REQ-035 Simultaneous requests SHALL be served in rr order; no requester waits more than n_masters-1 transfers.
REQ-036 grant_o SHALL equal the grant register.
REQ-037 ptr SHALL wrap mod n_masters; indices >= n_masters SHALL never be granted.

Reset
REQ-038 While rst_n_i=0, the block SHALL hold:
- state=IDLE, grant=0, ptr=0, cnt=0
- fml_stb=0, m_ack_o=0
- fml_adr/we/sel/do equal to requester 0's inputs.
REQ-039 Reset asserted mid-REQ or mid-BURST SHALL force fml_stb=0 and all m_ack_o=0 immediately; no pending state SHALL survive.
REQ-040 Rule: the first request after reset release SHALL be arbitrated with ptr=0.

Verification
REQ-041 Single request: m0 read at 0x100, ack 3 cycles after fml_stb -> fml_adr=0x100, m_ack_o[0] pulses with fml_ack, state back in IDLE 3 cycles after ack, ptr=1.
REQ-042 Contention: m0 and m1 strobe in the same cycle after reset -> m0 served first, then m1 (grant_o 0 then 1), then m0 again if it is still requesting.
REQ-043 Write mux: m1 write, sel=0x3, data 0xDEADBEEF -> fml_we=1, fml_sel=0x3, fml_do=0xDEADBEEF; m_ack_o[0] stays 0 throughout.
REQ-044 Abort: m1 drops its strobe in REQ before ack -> fml_stb falls the same cycle, IDLE next edge, ptr unchanged.
REQ-045 Reset mid-BURST with cnt=2 -> fml_stb=0 and m_ack_o=0 asynchronously; after release, m0 and m1 both requesting -> m0 granted.
REQ-046 n_masters=3, all three strobing continuously -> grant sequence 0,1,2,0; each transfer lasts burst_len cycles after ack.
